ic_ashr_cmp_witness_seq: RTL and testbench

- Sequential witness generator for the shift-amount invertibility problem: given s, t and a comparison op, search for x in [0, W-1] such that (s >>a x) op t holds, with op either unsigned less-than or unsigned greater-than.
- Parametrised-width successor to the fixed 4-bit combinational Skolem bit for bvult/bvashr; produces the full witness vector plus a found flag.
- Sits in the bit-vector solver acceleration path, driven by the propagation controller through a start/done handshake.

---
 rtl/ic_ashr_cmp_witness_seq.sv | 126 ++++++++++++
 tb/tb_ic_ashr_cmp_witness_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ic_ashr_cmp_witness_seq.sv
// Sequential witness search: find x in [0, W-1] with (s >>a x) op t, op = ULT/UGT.
// Optional macro IC_XCHECK_EN adds ic_err, a closed-form invertibility cross-check.
module ic_ashr_cmp_witness_seq #(
  parameter int W          = 4,
  parameter int SEARCH_DIR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  input  logic         op,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] x_out
`ifdef IC_XCHECK_EN
  ,
  output logic         ic_err
`endif
);

  localparam int KW = (W > 2) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);
  localparam logic [KW-1:0] K_INIT = (SEARCH_DIR != 0) ? K_LAST : '0;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t              state, state_nxt;
  logic signed [W-1:0] s_q;
  logic [W-1:0]        t_q;
  logic                op_q;
  logic [KW-1:0]       k;
  logic signed [W-1:0] r;
  logic                hit;
  logic                last;

  function automatic logic signed [W-1:0] asr(input logic signed [W-1:0] v,
                                              input logic [KW-1:0] sh);
    return v >>> sh;
  endfunction

  function automatic logic cmp_hit(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic use_ugt);
    return use_ugt ? (a > b) : (a < b);
  endfunction

  assign r    = asr(s_q, k);
  assign hit  = cmp_hit($unsigned(r), t_q, op_q);
  assign last = (SEARCH_DIR != 0) ? (k == '0) : (k == K_LAST);

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (hit || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, candidate stepping and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      t_q   <= '0;
      op_q  <= 1'b0;
      k     <= '0;
      found <= 1'b0;
      x_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          s_q   <= s;
          t_q   <= t;
          op_q  <= op;
          k     <= K_INIT;
          found <= 1'b0;
          x_out <= '0;
        end
        SEARCH: begin
          if (hit) begin
            found <= 1'b1;
            x_out <= {{(W-KW){1'b0}}, k};
          end else if (last) begin
            found <= 1'b0;
            x_out <= '0;
          end else if (SEARCH_DIR != 0) begin
            k <= k - K_ONE;
          end else begin
            k <= k + K_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IC_XCHECK_EN
  logic ic;

  // Closed form: a witness exists iff this holds for the latched operands
  always_ff @(posedge clk) begin
    if (rst) begin
      ic     <= 1'b0;
      ic_err <= 1'b0;
    end else if (state == IDLE && start) begin
      ic     <= op ? ((s[W-1] && (t != '1)) || (s > t))
                   : ((!s[W-1] && (t != '0)) || (s < t));
      ic_err <= 1'b0;
    end else if (state == DONE) begin
      ic_err <= (ic != found);
    end
  end
`endif

endmodule

// File: tb/tb_ic_ashr_cmp_witness_seq.sv
// Directed table-driven bench: ascending and descending searchers side by side, W=4.
module tb_ic_ashr_cmp_witness_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] s = '0;
  logic [W-1:0] t = '0;
  logic         op = 1'b0;
  logic         busy0, done0, found0, busy1, done1, found1;
  logic [W-1:0] x0, x1;
`ifdef IC_XCHECK_EN
  logic         ic_err0, ic_err1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic_ashr_cmp_witness_seq #(.W(W), .SEARCH_DIR(0)) dut_asc (
    .clk(clk), .rst(rst), .start(start), .s(s), .t(t), .op(op),
    .busy(busy0), .done(done0), .found(found0), .x_out(x0)
`ifdef IC_XCHECK_EN
    , .ic_err(ic_err0)
`endif
  );

  ic_ashr_cmp_witness_seq #(.W(W), .SEARCH_DIR(1)) dut_desc (
    .clk(clk), .rst(rst), .start(start), .s(s), .t(t), .op(op),
    .busy(busy1), .done(done1), .found(found1), .x_out(x1)
`ifdef IC_XCHECK_EN
    , .ic_err(ic_err1)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         op;
    logic         f_asc;
    int           x_asc;
    int           dc_asc;
    logic         f_desc;
    int           x_desc;
    int           dc_desc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Issue one request and observe both searchers for a bounded number of cycles
  task automatic run(input logic [W-1:0] sv, input logic [W-1:0] tv, input logic ov,
                     output int dc0, output int dc1, output int pulses0, output int pulses1,
                     output int busyc0, output int busyc1,
                     output logic f0, output int xo0, output logic f1, output int xo1);
    @(negedge clk);
    s = sv; t = tv; op = ov; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc0 = -1; dc1 = -1; pulses0 = 0; pulses1 = 0; busyc0 = 0; busyc1 = 0;
    f0 = 1'b0; f1 = 1'b0; xo0 = -1; xo1 = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (busy0) busyc0++;
      if (busy1) busyc1++;
      if (done0) begin
        pulses0++;
        if (dc0 < 0) begin dc0 = cyc; f0 = found0; xo0 = int'(x0); end
      end
      if (done1) begin
        pulses1++;
        if (dc1 < 0) begin dc1 = cyc; f1 = found1; xo1 = int'(x1); end
      end
    end
  endtask

  initial begin
    int dc0, dc1, p0, p1, b0, b1, xo0, xo1;
    logic f0, f1;

    vecs[0] = '{4'b0110, 4'b0010, 1'b0, 1'b1, 2, 4, 1'b1, 3, 2};
    vecs[1] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 0, 5, 1'b0, 0, 5};
    vecs[2] = '{4'b1000, 4'b1110, 1'b1, 1'b1, 3, 5, 1'b1, 3, 2};
    vecs[3] = '{4'b0101, 4'b0101, 1'b1, 1'b0, 0, 5, 1'b0, 0, 5};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 0, 5, 1'b0, 0, 5};
    vecs[5] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 5, 1'b0, 0, 5};
    vecs[6] = '{4'b1111, 4'b1110, 1'b1, 1'b1, 0, 2, 1'b1, 3, 2};
    vecs[7] = '{4'b0111, 4'b0001, 1'b0, 1'b1, 3, 5, 1'b1, 3, 2};
    vecs[8] = '{4'b1000, 4'b1111, 1'b1, 1'b0, 0, 5, 1'b0, 0, 5};
    vecs[9] = '{4'b0100, 4'b0011, 1'b0, 1'b1, 1, 3, 1'b1, 3, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset found", int'(found0), 0);
    chk("reset x_out", int'(x0), 0);
    chk("reset desc busy", int'(busy1), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(vecs[i].s, vecs[i].t, vecs[i].op, dc0, dc1, p0, p1, b0, b1, f0, xo0, f1, xo1);
      chk($sformatf("v%0d asc done cycle", i), dc0, vecs[i].dc_asc);
      chk($sformatf("v%0d asc found", i), int'(f0), int'(vecs[i].f_asc));
      chk($sformatf("v%0d asc x_out", i), xo0, vecs[i].x_asc);
      chk($sformatf("v%0d asc done pulses", i), p0, 1);
      chk($sformatf("v%0d asc busy cycles", i), b0, vecs[i].dc_asc - 1);
      chk($sformatf("v%0d asc found held", i), int'(found0), int'(vecs[i].f_asc));
      chk($sformatf("v%0d asc x_out held", i), int'(x0), vecs[i].x_asc);
      chk($sformatf("v%0d desc done cycle", i), dc1, vecs[i].dc_desc);
      chk($sformatf("v%0d desc found", i), int'(f1), int'(vecs[i].f_desc));
      chk($sformatf("v%0d desc x_out", i), xo1, vecs[i].x_desc);
      chk($sformatf("v%0d desc done pulses", i), p1, 1);
`ifdef IC_XCHECK_EN
      chk($sformatf("v%0d asc ic_err", i), int'(ic_err0), 0);
      chk($sformatf("v%0d desc ic_err", i), int'(ic_err1), 0);
`endif
    end

    // Second start during SEARCH must be ignored
    @(negedge clk);
    s = 4'b0110; t = 4'b0010; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    s = 4'b1000; t = 4'b1110; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc0 = -1; p0 = 0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done0) begin
        p0++;
        if (dc0 < 0) begin dc0 = cyc; f0 = found0; xo0 = int'(x0); end
      end
    end
    chk("restart done cycle", dc0, 4);
    chk("restart found", int'(f0), 1);
    chk("restart x_out", xo0, 2);
    chk("restart done pulses", p0, 1);

    // Reset asserted in cycle 2 of a search
    @(negedge clk);
    s = 4'b0110; t = 4'b0010; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", int'(busy0), 0);
    chk("midrst done", int'(done0), 0);
    chk("midrst found", int'(found0), 0);
    chk("midrst x_out", int'(x0), 0);
    chk("midrst desc found", int'(found1), 0);
    p0 = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done0 || busy0) p0++;
    end
    chk("midrst stays idle", p0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
